alu_seq_param: RTL

- Parametrised, handshaked successor to the team's 8-bit registered ALU.
- Operand width is set by WIDTH.
- Division is a multi-cycle restoring divider that returns both quotient and remainder; all other operations complete in one cycle.
- Sits between the register-file/command decoder and the result path in the system clock domain. Back-pressures upstream through IN_READY while a division is running.

---
 rtl/alu_seq_param.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/alu_seq_param.sv
// Parametrised handshaked ALU: single-cycle arithmetic/logic ops plus a
// multi-cycle restoring divider that back-pressures upstream while running.
`timescale 1ns/1ps
module alu_seq_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [3:0]           ALU_FUN,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic [2*WIDTH-1:0]   ALU_OUT,
    output logic                 OUT_VALID,
    output logic                 DIV_ERR,
    output logic                 BUSY
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DIV  = 1'b1
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_dvs;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_alu_out;
    logic                 r_out_valid;
    logic                 r_div_err;

    logic [2*WIDTH-1:0]   w_a_ext;
    logic [2*WIDTH-1:0]   w_b_ext;
    logic [2*WIDTH-1:0]   w_result;
    logic                 w_op_valid;
    logic                 w_div_err;
    logic [WIDTH:0]       w_trial;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_rem_nxt;
    logic [WIDTH-1:0]     w_quo_nxt;

    assign w_a_ext   = {{WIDTH{1'b0}}, A};
    assign w_b_ext   = {{WIDTH{1'b0}}, B};
    assign IN_READY  = (r_state == IDLE);
    assign BUSY      = (r_state == DIV);
    assign ALU_OUT   = r_alu_out;
    assign OUT_VALID = r_out_valid;
    assign DIV_ERR   = r_div_err;

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        w_trial = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};
        w_ge    = ~w_trial[WIDTH];
        if (w_ge) begin
            w_rem_nxt = w_trial[WIDTH-1:0];
        end else begin
            w_rem_nxt = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
        end
        w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
    end

    // Single-cycle result decode; the 0011 arm is only reached when B is zero.
    always_comb begin
        w_result   = {(2*WIDTH){1'b0}};
        w_op_valid = 1'b1;
        w_div_err  = 1'b0;
        case (ALU_FUN)
            4'b0000: w_result = w_a_ext + w_b_ext;
            4'b0001: w_result = w_a_ext - w_b_ext;
            4'b0010: w_result = w_a_ext * w_b_ext;
            4'b0011: w_div_err = 1'b1;
            4'b0100: w_result = {{WIDTH{1'b0}}, A & B};
            4'b0101: w_result = {{WIDTH{1'b0}}, A | B};
            4'b0110: w_result = {{WIDTH{1'b0}}, ~(A & B)};
            4'b0111: w_result = {{WIDTH{1'b0}}, ~(A | B)};
            4'b1000: w_result = {{WIDTH{1'b0}}, A ^ B};
            4'b1001: w_result = {{WIDTH{1'b0}}, ~(A ^ B)};
            4'b1010: w_result = (A == B) ? (2*WIDTH)'(1) : {(2*WIDTH){1'b0}};
            4'b1011: w_result = (A > B)  ? (2*WIDTH)'(2) : {(2*WIDTH){1'b0}};
            4'b1100: w_result = (A < B)  ? (2*WIDTH)'(3) : {(2*WIDTH){1'b0}};
            4'b1101: w_result = w_a_ext >> 1;
            4'b1110: w_result = w_a_ext << 1;
            4'b1111: w_op_valid = 1'b0;
            default: w_op_valid = 1'b0;
        endcase
    end

    // Control FSM, divider datapath and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= IDLE;
            r_rem       <= {WIDTH{1'b0}};
            r_quo       <= {WIDTH{1'b0}};
            r_dvs       <= {WIDTH{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_alu_out   <= {(2*WIDTH){1'b0}};
            r_out_valid <= 1'b0;
            r_div_err   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (IN_VALID) begin
                        if ((ALU_FUN == 4'b0011) && (B != {WIDTH{1'b0}})) begin
                            r_state <= DIV;
                            r_rem   <= {WIDTH{1'b0}};
                            r_quo   <= A;
                            r_dvs   <= B;
                            r_cnt   <= {CNT_W{1'b0}};
                        end else if (w_op_valid) begin
                            r_alu_out   <= w_result;
                            r_div_err   <= w_div_err;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                DIV: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state     <= IDLE;
                        r_cnt       <= {CNT_W{1'b0}};
                        r_alu_out   <= {w_rem_nxt, w_quo_nxt};
                        r_div_err   <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
